// File: rtl/genesys_axi_pkg.sv
// rtl/genesys_axi_pkg.sv - AXI encodings, page size and loader state enum
package genesys_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        LD_IDLE     = 3'd0,
        LD_ARMED    = 3'd1,
        LD_BLOCK    = 3'd2,
        LD_BLK_DONE = 3'd3,
        LD_DRAIN    = 3'd4,
        LD_FINISH   = 3'd5
    } loader_state_e;

endpackage

// File: rtl/axi_burst_planner.sv
// rtl/axi_burst_planner.sv - burst length limited by MAX_BURST, beats left and the 4 KB page
module axi_burst_planner
    import genesys_axi_pkg::*;
#(
    parameter int BEAT_BYTES = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic [11:0] page_offset,
    input  logic [31:0] req_left,
    output logic [8:0]  burst_len
);

    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

    logic [12:0] page_room;
    logic [12:0] page_beats;

    always_comb begin
        page_room  = 13'(AXI_PAGE_BYTES) - {1'b0, page_offset};
        page_beats = page_room >> BEAT_SHIFT;
        burst_len  = 9'(MAX_BURST);
        if (req_left < 32'(burst_len))
            burst_len = req_left[8:0];
        // Once smaller than a len that fits in 9 bits, page_beats fits as well.
        if (page_beats < 13'(burst_len))
            burst_len = page_beats[8:0];
    end

endmodule

// File: rtl/inst_block_loader.sv
// rtl/inst_block_loader.sv - AXI4 read master feeding instruction memory one block at a time
module inst_block_loader
    import genesys_axi_pkg::*;
#(
    parameter int NUM_INST_IN     = 2,
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [AXI_ADDR_WIDTH-1:0]              inst_base_addr,
    input  logic [31:0]                            inst_num_beats,
    input  logic                                   genesys_done,
    input  logic                                   imem_wr_start,
    output logic                                   imem_wr_data_valid,
    output logic [NUM_INST_IN*INST_DATA_WIDTH-1:0] imem_wr_data,
    output logic                                   imem_wr_done,
    output logic                                   loader_done,
    output logic                                   rresp_err,
    output logic [AXI_ADDR_WIDTH-1:0]              m_axi_araddr,
    output logic [7:0]                             m_axi_arlen,
    output logic [2:0]                             m_axi_arsize,
    output logic [1:0]                             m_axi_arburst,
    output logic                                   m_axi_arvalid,
    input  logic                                   m_axi_arready,
    input  logic [NUM_INST_IN*INST_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                             m_axi_rresp,
    input  logic                                   m_axi_rlast,
    input  logic                                   m_axi_rvalid,
    output logic                                   m_axi_rready
);

    localparam int DATA_W      = NUM_INST_IN * INST_DATA_WIDTH;
    localparam int BEAT_BYTES  = DATA_W / 8;
    localparam int BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int BLOCK_BEATS = (1 << INST_ADDR_WIDTH) / NUM_INST_IN;

    localparam logic [2:0] S_IDLE     = LD_IDLE;
    localparam logic [2:0] S_ARMED    = LD_ARMED;
    localparam logic [2:0] S_BLOCK    = LD_BLOCK;
    localparam logic [2:0] S_BLK_DONE = LD_BLK_DONE;
    localparam logic [2:0] S_DRAIN    = LD_DRAIN;
    localparam logic [2:0] S_FINISH   = LD_FINISH;

    logic [2:0]                state, next_state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [31:0]               remaining;
    logic [31:0]               blk_beats;
    logic [31:0]               req_left;
    logic [31:0]               recv_left;
    logic [7:0]                outstanding, out_next;
    logic [8:0]                ar_beats;

    logic        ar_hs, r_hs, rlast_hs, issue, abort_busy;
    logic [31:0] blk_new, plan_req;
    logic [8:0]  plan_len;

    assign ar_hs      = m_axi_arvalid & m_axi_arready;
    assign r_hs       = m_axi_rvalid & m_axi_rready;
    assign rlast_hs   = r_hs & m_axi_rlast;
    assign abort_busy = (outstanding != 8'd0) || m_axi_arvalid;
    assign blk_new    = (remaining < 32'(BLOCK_BEATS)) ? remaining : 32'(BLOCK_BEATS);
    // The first burst of a block is planned in ARMED so arvalid rises one cycle after imem_wr_start.
    assign plan_req   = (state == S_ARMED) ? blk_new : req_left;

    axi_burst_planner #(
        .BEAT_BYTES(BEAT_BYTES),
        .MAX_BURST (MAX_BURST)
    ) u_planner (
        .page_offset(addr[11:0]),
        .req_left   (plan_req),
        .burst_len  (plan_len)
    );

    always_comb begin
        issue = 1'b0;
        if (!genesys_done && !m_axi_arvalid && (outstanding < 8'(MAX_OUTSTANDING))) begin
            if (state == S_ARMED && imem_wr_start)
                issue = 1'b1;
            else if (state == S_BLOCK && req_left != 32'd0)
                issue = 1'b1;
        end
    end

    always_comb begin
        out_next = outstanding;
        if (ar_hs && !rlast_hs)
            out_next = outstanding + 8'd1;
        else if (!ar_hs && rlast_hs)
            out_next = outstanding - 8'd1;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start)
                    next_state = (inst_num_beats == 32'd0) ? S_FINISH : S_ARMED;
            end
            S_ARMED: begin
                if (genesys_done)
                    next_state = abort_busy ? S_DRAIN : S_FINISH;
                else if (imem_wr_start)
                    next_state = S_BLOCK;
            end
            S_BLOCK: begin
                if (genesys_done)
                    next_state = abort_busy ? S_DRAIN : S_FINISH;
                else if (r_hs && recv_left == 32'd1)
                    next_state = S_BLK_DONE;
            end
            S_BLK_DONE: begin
                if (genesys_done || remaining == blk_beats)
                    next_state = S_FINISH;
                else
                    next_state = S_ARMED;
            end
            // Wait for a still-presented AR too, so its data is not left in flight.
            S_DRAIN: begin
                if (outstanding == 8'd0 && !m_axi_arvalid)
                    next_state = S_FINISH;
            end
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            addr               <= '0;
            remaining          <= '0;
            blk_beats          <= '0;
            req_left           <= '0;
            recv_left          <= '0;
            outstanding        <= '0;
            ar_beats           <= '0;
            imem_wr_data_valid <= 1'b0;
            imem_wr_data       <= '0;
            imem_wr_done       <= 1'b0;
            loader_done        <= 1'b0;
            rresp_err          <= 1'b0;
            m_axi_araddr       <= '0;
            m_axi_arlen        <= '0;
            m_axi_arsize       <= '0;
            m_axi_arburst      <= '0;
            m_axi_arvalid      <= 1'b0;
            m_axi_rready       <= 1'b0;
        end else begin
            state              <= next_state;
            outstanding        <= out_next;
            imem_wr_data_valid <= 1'b0;
            imem_wr_done       <= 1'b0;
            loader_done        <= 1'b0;
            m_axi_rready       <= (next_state == S_BLOCK) || (next_state == S_DRAIN);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= inst_base_addr;
                        remaining <= inst_num_beats;
                        rresp_err <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (imem_wr_start && !genesys_done) begin
                        blk_beats <= blk_new;
                        req_left  <= blk_new;
                        recv_left <= blk_new;
                    end
                end
                S_BLK_DONE: begin
                    imem_wr_done <= 1'b1;
                    remaining    <= remaining - blk_beats;
                end
                S_FINISH: loader_done <= 1'b1;
                default: ;
            endcase

            if (issue) begin
                m_axi_arvalid <= 1'b1;
                m_axi_araddr  <= addr;
                m_axi_arlen   <= 8'(plan_len - 9'd1);
                m_axi_arsize  <= 3'(BEAT_SHIFT);
                m_axi_arburst <= AXI_BURST_INCR;
                ar_beats      <= plan_len;
            end else if (ar_hs) begin
                m_axi_arvalid <= 1'b0;
                addr          <= addr + (AXI_ADDR_WIDTH'(ar_beats) << BEAT_SHIFT);
                req_left      <= req_left - 32'(ar_beats);
            end

            if (r_hs) begin
                if (m_axi_rresp != AXI_RESP_OKAY)
                    rresp_err <= 1'b1;
                if (state == S_BLOCK) begin
                    imem_wr_data       <= m_axi_rdata;
                    imem_wr_data_valid <= 1'b1;
                    recv_left          <= recv_left - 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_block_loader.sv
// tb/tb_inst_block_loader.sv - self-checking bench with AXI slave model and stream scoreboard
module tb_inst_block_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] inst_base_addr = '0;
    logic [31:0] inst_num_beats = '0;
    logic        genesys_done = 1'b0;
    logic        imem_wr_start = 1'b0;
    logic        imem_wr_data_valid;
    logic [63:0] imem_wr_data;
    logic        imem_wr_done;
    logic        loader_done;
    logic        rresp_err;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    inst_block_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .inst_base_addr(inst_base_addr), .inst_num_beats(inst_num_beats),
        .genesys_done(genesys_done), .imem_wr_start(imem_wr_start),
        .imem_wr_data_valid(imem_wr_data_valid), .imem_wr_data(imem_wr_data),
        .imem_wr_done(imem_wr_done), .loader_done(loader_done), .rresp_err(rresp_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int len; } burst_t;
    typedef struct {
        logic [63:0] base; int beats; int ar_pct; int r_pct; int err_beat;
        int exp_blocks; int exp_ars; logic exp_err;
    } vec_t;

    int total = 0, bad = 0;
    int cyc = 0;
    burst_t      ar_q[$];
    burst_t      exp_ar_q[$];
    logic [63:0] exp_beat_q[$];
    int          exp_blk_q[$];
    int  ar_pct = 100, r_pct = 100, err_beat = -1;
    bit  r_hold = 1'b0, check_ar_seq = 1'b1, chk_lat = 1'b1;
    int  r_idx = 0, r_beat_cnt = 0, ar_hs_cnt = 0, done_cnt = 0, ldone_cnt = 0;
    int  blk_valid_cnt = 0, last_valid_cyc = -10;
    bit  block_open = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hDEADBEEF, a[31:0]};
    endfunction

    // Reference: program split into 512-beat blocks, each into bursts that stop at
    // 16 beats, the end of the block, or the end of the 4 KB page.
    function automatic void build_expect(input logic [63:0] base, input int beats);
        logic [63:0] a;
        int left, blk, rem, room, n;
        burst_t b;
        exp_beat_q.delete(); exp_ar_q.delete(); exp_blk_q.delete();
        for (int i = 0; i < beats; i++) exp_beat_q.push_back(mem_word(base + 64'(i) * 64'd8));
        a = base; left = beats;
        while (left > 0) begin
            blk = (left < 512) ? left : 512;
            exp_blk_q.push_back(blk);
            left -= blk; rem = blk;
            while (rem > 0) begin
                room = (4096 - int'(a % 4096)) / 8;
                n = 16;
                if (rem < n) n = rem;
                if (room < n) n = room;
                b.addr = a; b.len = n;
                exp_ar_q.push_back(b);
                a += 64'(n) * 64'd8; rem -= n;
            end
        end
    endfunction

    // AXI slave and output monitor: decide handshakes at negedge, drive after posedge.
    initial begin
        bit ar_hs, r_hs, prev_stall, lat_pending;
        logic [63:0] prev_addr; logic [7:0] prev_len;
        burst_t e;
        prev_stall = 0; lat_pending = 0; prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ar_hs = m_axi_arvalid && m_axi_arready;
                r_hs  = m_axi_rvalid && m_axi_rready;
                if (prev_stall) begin
                    chk("ar_hold_valid", m_axi_arvalid, 1);
                    chk("ar_hold_addr", m_axi_araddr, prev_addr);
                    chk("ar_hold_len", m_axi_arlen, prev_len);
                end
                if (lat_pending && chk_lat) chk("ar_first_latency", m_axi_arvalid, 1);
                lat_pending = imem_wr_start;
                prev_stall = m_axi_arvalid && !m_axi_arready;
                prev_addr = m_axi_araddr; prev_len = m_axi_arlen;
                if (m_axi_arvalid) chk("arburst_incr", m_axi_arburst, 2'b01);
                if (ar_hs) begin
                    ar_hs_cnt++;
                    chk("arsize", m_axi_arsize, 3);
                    chk("ar_no_4k_cross", (m_axi_araddr % 4096) + (64'(m_axi_arlen) + 1) * 8 <= 4096, 1);
                    if (check_ar_seq) begin
                        chk("ar_expected", exp_ar_q.size() > 0, 1);
                        if (exp_ar_q.size() > 0) begin
                            e = exp_ar_q.pop_front();
                            chk("ar_addr", m_axi_araddr, e.addr);
                            chk("ar_len", m_axi_arlen, 64'(e.len - 1));
                        end
                    end
                    e.addr = m_axi_araddr; e.len = int'(m_axi_arlen) + 1;
                    ar_q.push_back(e);
                end
                if (r_hs) begin
                    r_beat_cnt++;
                    if (m_axi_rlast) begin r_idx = 0; void'(ar_q.pop_front()); end
                    else r_idx++;
                end
                if (ar_q.size() > 2) chk("outstanding_le_2", ar_q.size(), 2);
                if (imem_wr_start) block_open = 1;
                if (imem_wr_data_valid) begin
                    chk("valid_inside_block", block_open, 1);
                    chk("beat_expected", exp_beat_q.size() > 0, 1);
                    if (exp_beat_q.size() > 0) chk("beat_data", imem_wr_data, exp_beat_q.pop_front());
                    blk_valid_cnt++;
                    last_valid_cyc = cyc;
                end
                if (imem_wr_done) begin
                    chk("done_after_last_valid", cyc - last_valid_cyc, 1);
                    chk("done_expected", exp_blk_q.size() > 0, 1);
                    if (exp_blk_q.size() > 0) chk("block_beats", blk_valid_cnt, exp_blk_q.pop_front());
                    blk_valid_cnt = 0; block_open = 0; done_cnt++;
                end
                if (loader_done) ldone_cnt++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (reset) begin
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
            end else begin
                m_axi_arready = ($urandom_range(99) < ar_pct);
                if (!(m_axi_rvalid && !r_hs)) begin
                    if (ar_q.size() > 0 && !r_hold && $urandom_range(99) < r_pct) begin
                        m_axi_rvalid = 1;
                        m_axi_rdata  = mem_word(ar_q[0].addr + 64'(r_idx) * 64'd8);
                        m_axi_rlast  = (r_idx == ar_q[0].len - 1);
                        m_axi_rresp  = (r_beat_cnt == err_beat) ? 2'b10 : 2'b00;
                    end else begin
                        m_axi_rvalid = 0; m_axi_rlast = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_counts();
        ar_hs_cnt = 0; done_cnt = 0; ldone_cnt = 0; r_beat_cnt = 0; blk_valid_cnt = 0;
    endtask

    task automatic run_program(input vec_t v);
        int guard, bound;
        ar_pct = v.ar_pct; r_pct = v.r_pct; err_beat = v.err_beat;
        check_ar_seq = 1; chk_lat = 1;
        build_expect(v.base, v.beats);
        clear_counts();
        bound = 40 * v.beats + 500;
        inst_base_addr = v.base; inst_num_beats = 32'(v.beats); start = 1;
        tick(); start = 0;
        for (int b = 0; b < v.exp_blocks; b++) begin
            repeat ($urandom_range(1, 3)) tick();
            imem_wr_start = 1; tick(); imem_wr_start = 0;
            guard = 0;
            while (done_cnt <= b && guard < bound) begin tick(); guard++; end
            if (guard >= bound) begin chk("block_timeout", done_cnt, b + 1); break; end
        end
        guard = 0;
        while (ldone_cnt == 0 && guard < 100) begin tick(); guard++; end
        repeat (3) tick();
        chk("loader_done_pulses", ldone_cnt, 1);
        chk("n_blocks", done_cnt, v.exp_blocks);
        chk("n_ars", ar_hs_cnt, v.exp_ars);
        chk("beats_left", exp_beat_q.size(), 0);
        chk("rresp_err", rresp_err, v.exp_err);
        chk("rready_idle", m_axi_rready, 0);
    endtask

    vec_t vecs[8];

    initial begin
        int guard, hs_limit;
        vecs[0] = '{64'h1000, 40,   100, 100, -1, 1, 3,  1'b0};
        vecs[1] = '{64'h0,    1100, 100, 100, -1, 3, 69, 1'b0};
        vecs[2] = '{64'h0FF0, 8,    100, 100, -1, 1, 2,  1'b0};
        vecs[3] = '{64'h3000, 48,   20,  50,  3,  1, 3,  1'b1};
        for (int i = 4; i < 8; i++) begin
            vecs[i].base   = (64'($urandom_range(0, 65535)) << 12) | (64'($urandom_range(0, 511)) << 3);
            vecs[i].beats  = $urandom_range(1, 700);
            vecs[i].ar_pct = $urandom_range(40, 100);
            vecs[i].r_pct  = $urandom_range(40, 100);
            vecs[i].err_beat = ($urandom_range(3) == 0) ? $urandom_range(0, vecs[i].beats - 1) : -1;
            vecs[i].exp_err  = (vecs[i].err_beat >= 0);
            build_expect(vecs[i].base, vecs[i].beats);
            vecs[i].exp_blocks = exp_blk_q.size();
            vecs[i].exp_ars    = exp_ar_q.size();
        end
        exp_beat_q.delete(); exp_ar_q.delete(); exp_blk_q.delete();

        repeat (3) tick();
        chk("rst_ctrl", {imem_wr_data_valid, imem_wr_done, loader_done, rresp_err,
                         m_axi_arvalid, m_axi_rready, m_axi_arburst, m_axi_arlen, m_axi_arsize}, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_wdata", imem_wr_data, 0);
        reset = 0;
        tick();

        // Empty program: loader_done two cycles after start, no AR.
        clear_counts();
        inst_num_beats = 0; start = 1; tick(); start = 0;
        chk("zero_done_early", loader_done, 0);
        tick();
        chk("zero_done_at_2", loader_done, 1);
        tick();
        chk("zero_no_ar", ar_hs_cnt + int'(m_axi_arvalid), 0);

        // imem_wr_start in IDLE is ignored; then abort after the first AR is accepted.
        chk_lat = 0; check_ar_seq = 0; r_hold = 1; ar_pct = 100; err_beat = -1;
        clear_counts();
        imem_wr_start = 1; tick(); imem_wr_start = 0; tick();
        inst_base_addr = 64'h2000; inst_num_beats = 64; start = 1; tick(); start = 0;
        repeat (4) tick();
        chk("ignored_wr_start", ar_hs_cnt + int'(m_axi_arvalid), 0);
        chk_lat = 1;
        imem_wr_start = 1; tick(); imem_wr_start = 0;
        guard = 0;
        while (ar_hs_cnt < 1 && guard < 50) begin tick(); guard++; end
        chk("abort_first_ar", ar_hs_cnt >= 1, 1);
        genesys_done = 1;
        hs_limit = ar_hs_cnt + int'(m_axi_arvalid);
        tick(); genesys_done = 0;
        repeat (3) tick();
        r_hold = 0;
        guard = 0;
        while (ldone_cnt == 0 && guard < 500) begin tick(); guard++; end
        repeat (2) tick();
        chk("abort_loader_done", ldone_cnt, 1);
        chk("abort_no_new_ar", ar_hs_cnt <= hs_limit, 1);
        chk("abort_drained", ar_q.size(), 0);
        chk("abort_no_wr_done", done_cnt, 0);
        r_idx = 0;

        for (int i = 0; i < 8; i++) run_program(vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_block_loader.md
# inst_block_loader

Fetches a program's instruction stream from off-chip memory over an AXI4 read master and delivers it to the instruction memory's ping-pong write port one block at a time. It sits between the AXI interconnect and `instruction_memory`, driving that block's `imem_wr_data_valid` / `imem_wr_data` / `imem_wr_done` inputs and obeying its `imem_wr_start` block request. It splits each block into INCR bursts, honouring a maximum burst length, 4 KB boundaries and an outstanding-burst limit.

## Interface
- NUM_INST_IN, 2, instructions packed per AXI beat.
- INST_DATA_WIDTH, 32, bits per instruction; AXI data width = NUM_INST_IN*INST_DATA_WIDTH.
- INST_ADDR_WIDTH, 10, imem read address width; block capacity BLOCK_BEATS = 2^INST_ADDR_WIDTH / NUM_INST_IN beats.
- AXI_ADDR_WIDTH, 64, byte address width.
- MAX_BURST, 16, maximum beats per AR (power of two, ≤256).
- MAX_OUTSTANDING, 2, maximum AR bursts awaiting their rlast.
- clk  in  1  clock. One clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches inst_base_addr and inst_num_beats.
- inst_base_addr  in  AXI_ADDR_WIDTH  program byte address, beat-aligned.
- inst_num_beats  in  32  total program length in beats.
- genesys_done  in  1  abort; stop fetching, drain, go idle.
- imem_wr_start  in  1  one-cycle pulse from imem: a free buffer is ready for a block.
- imem_wr_data_valid  out  1  one beat written this cycle.
- imem_wr_data  out  NUM_INST_IN*INST_DATA_WIDTH  beat payload.
- imem_wr_done  out  1  one-cycle pulse; current block complete.
- loader_done  out  1  one-cycle pulse; whole program delivered or abort drained.
- rresp_err  out  1  sticky; set on any rresp≠OKAY, cleared by start.
- m_axi_araddr / arlen / arsize / arburst / arvalid  out  AXI_ADDR_WIDTH / 8 / 3 / 2 / 1.
- m_axi_arready  in  1.
- m_axi_rdata / rresp / rlast / rvalid  in  data width / 2 / 1 / 1.
- m_axi_rready  out  1.

## Operation
- FSM states: IDLE, ARMED, BLOCK, BLK_DONE, DRAIN, FINISH.
- IDLE: start → latch addr and remaining = inst_num_beats; clear rresp_err; go ARMED. If inst_num_beats = 0, go FINISH instead.
- ARMED: imem_wr_start → blk_beats = min(remaining, BLOCK_BEATS); req_left = recv_left = blk_beats; go BLOCK.
- BLOCK, AR side: when req_left > 0, arvalid is low and outstanding < MAX_OUTSTANDING, issue a burst with len = min(MAX_BURST, req_left, (4096 − addr[11:0]) / beat_bytes). Drive arlen = len−1, arsize = log2(beat_bytes), arburst = INCR. Hold arvalid and all AR fields stable until arready. On handshake, addr += len*beat_bytes, req_left −= len, and outstanding increments.
- BLOCK, R side: rready = 1. On each R handshake, register rdata into imem_wr_data, assert imem_wr_data_valid, and decrement recv_left. rlast decrements outstanding. The same-cycle AR handshake and rlast leave outstanding unchanged. recv_left reaching 0 moves the FSM to BLK_DONE.
- BLK_DONE: pulse imem_wr_done; remaining −= blk_beats. Go ARMED if remaining > 0, else FINISH.
- FINISH: pulse loader_done; go IDLE.
- genesys_done in any non-IDLE state: no new AR is issued; an AR already presented stays valid until accepted. If outstanding > 0, go DRAIN, otherwise go FINISH.
- DRAIN: rready = 1, beats are discarded, imem_wr_data_valid stays 0. When outstanding reaches 0, go FINISH.
- start outside IDLE is ignored. imem_wr_start outside ARMED is ignored.
- Async reset mid-burst returns to IDLE immediately. AXI recovery is the system reset's responsibility.

## Timing
- All outputs are registered. Reset value of every output is 0; arburst resets to 0 and reads 2'b01 whenever arvalid is high.
- imem_wr_data_valid asserts 1 cycle after the R handshake. Sustained throughput is 1 beat/cycle.
- imem_wr_done asserts the cycle after the last imem_wr_data_valid of a block.
- The first arvalid asserts 1 cycle after imem_wr_start is sampled.
- loader_done asserts 1 cycle after the final imem_wr_done, or 1 cycle after the drain completes.
- rready = 0 in IDLE, ARMED, BLK_DONE and FINISH.

## Structure
- Shared package `genesys_axi_pkg`: AXI burst/resp encodings (INCR, OKAY), 4 KB page constant, and the loader state enum.
- One natural sub-module, `axi_burst_planner`: combinational len calculation from addr, req_left, MAX_BURST and the 4 KB boundary.
- Everything else (counters, FSM, AR/R logic) lives in the top module.

## Test plan
- Base 0x1000, 40 beats, BLOCK_BEATS = 512, arready/rvalid always high → AR lens 16, 16, 8; 40 valid beats; one imem_wr_done; then loader_done.
- 1100 beats with imem_wr_start issued three times → blocks of 512, 512 and 76 beats; three imem_wr_done pulses. No valid beats while ARMED.
- Base 0x0FF0, 8 beats of 8 bytes → first AR len 2 (arlen = 1) at 0x0FF0, second AR len 6 at 0x1000.
- arready held low 5 cycles, rvalid toggling, with MAX_OUTSTANDING = 2 → AR fields stay stable, outstanding never exceeds 2, data order preserved.
- genesys_done asserted after 1 of 2 outstanding bursts is accepted → no further AR, remaining beats drained with imem_wr_data_valid = 0, then loader_done; next start works.
- rresp = SLVERR on beat 3 → rresp_err = 1 and the data is still written. inst_num_beats = 0 → loader_done 2 cycles after start with no AR issued.
